keypad_entry_tx: RTL and testbench

Keypad-side transmitter for the digital lock. It takes raw, bouncy push-button levels from the dedicated inputs and synchronizes and debounces them. It encodes each accepted press as one 4-bit key code and delivers it to the lock core over a valid/ready handshake, which the lock core consumes as receiver. Each physical press produces exactly one transfer.

---
 rtl/keypad_entry_tx.sv | 136 +++++++++++++
 tb/tb_keypad_entry_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_tx.sv
// Keypad transmitter: synchronizes and debounces 12 raw buttons, sends one 4-bit key code
// per accepted press over valid/ready. Define KEY_REPEAT_EN to auto-repeat held digit keys.
module keypad_entry_tx #(
   parameter int DB_CYCLES     = 16,
   parameter int REPEAT_CYCLES = 200
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [11:0] btn,
   output logic [3:0]  tx_code,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SEND    = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;
   localparam logic [7:0] DB_MATCH = 8'(DB_CYCLES);

   if (DB_CYCLES < 2 || DB_CYCLES > 255 || REPEAT_CYCLES < 1) begin : g_bad_cfg
      $error("keypad_entry_tx: DB_CYCLES must be 2..255 and REPEAT_CYCLES >= 1");
   end

   logic [11:0] sync_q;
   logic [11:0] s;
   logic [11:0] prev;
   logic [7:0]  cnt;
   logic [7:0]  cnt_next;
   logic [1:0]  state;
   logic        db_hit;
   logic        one_hot;
   logic [3:0]  key_idx;

   // NOTE: the synchronizer and debounce flops are async-reset too, so a fresh debounce
   // is always required after reset even if a key is still held.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q <= '0;
         s      <= '0;
         prev   <= '0;
         cnt    <= '0;
      end else begin
         sync_q <= btn;
         s      <= sync_q;
         prev   <= s;
         cnt    <= cnt_next;
      end
   end

   always_comb begin
      if (s != prev)
         cnt_next = '0;
      else if (cnt == 8'hFF)
         cnt_next = cnt;
      else
         cnt_next = cnt + 8'd1;
   end

   // Fires once per stable run: the edge where the count first lands on DB_CYCLES.
   assign db_hit  = (cnt_next == DB_MATCH) && (cnt_next != cnt);
   assign one_hot = (s != '0) && ((s & (s - 12'd1)) == '0);

   always_comb begin
      key_idx = 4'd0;
      for (int i = 0; i < 12; i++) begin
         if (s[i]) key_idx = 4'(i);
      end
   end

`ifdef KEY_REPEAT_EN
   localparam int            HW        = $clog2(REPEAT_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_CYCLES - 1);

   logic [HW-1:0] hold;
   logic          repeat_key;

   // Only digits repeat, and only while that same single key stays down.
   assign repeat_key = (tx_code <= 4'd9) && (s == (12'd1 << tx_code));
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         tx_valid <= 1'b0;
         tx_code  <= 4'd0;
`ifdef KEY_REPEAT_EN
         hold     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (one_hot && db_hit) begin
                  state    <= SEND;
                  tx_valid <= 1'b1;
                  tx_code  <= key_idx;
               end
            end
            SEND: begin
               if (tx_ready) begin
                  state    <= RELEASE;
                  tx_valid <= 1'b0;
`ifdef KEY_REPEAT_EN
                  hold     <= '0;
`endif
               end
            end
            RELEASE: begin
               if (s == '0 && db_hit) begin
                  state <= IDLE;
               end
`ifdef KEY_REPEAT_EN
               else if (repeat_key) begin
                  if (hold == HOLD_LAST) begin
                     state    <= SEND;
                     tx_valid <= 1'b1;
                     hold     <= '0;
                  end else begin
                     hold <= hold + HW'(1);
                  end
               end else begin
                  hold <= '0;
               end
`endif
            end
            default: begin
               state    <= IDLE;
               tx_valid <= 1'b0;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_keypad_entry_tx.sv
// Bench for keypad_entry_tx: directed test-plan steps plus random button traffic, each
// cycle compared against a history-based reference model of the debounce/handshake rules.
module tb_keypad_entry_tx;

   localparam int DB  = 4;
   localparam int RPT = 20;
`ifdef KEY_REPEAT_EN
   localparam int HOLD_XFERS = 3;
`else
   localparam int HOLD_XFERS = 1;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [11:0] btn = '0;
   logic        tx_ready = 1'b0;
   logic [3:0]  tx_code;
   logic        tx_valid;
   logic        busy;

   always #5 clk = ~clk;

   keypad_entry_tx #(.DB_CYCLES(DB), .REPEAT_CYCLES(RPT)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .btn      (btn),
      .tx_code  (tx_code),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy)
   );

   typedef enum int {M_IDLE, M_SEND, M_RELEASE} mode_t;

   mode_t       mode;
   logic [3:0]  m_code;
   int          m_held;
   logic [11:0] hist[$];   // btn value seen at each edge since reset, zero-padded in front

   int          vectors = 0;
   int          miscompares = 0;
   int          dut_xfers = 0;
   logic [3:0]  last_code = '0;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // True when the sample at index j closes a run of exactly DB+1 identical edges.
   function automatic bit stable_hit(int j);
      for (int d = 1; d <= DB; d++) begin
         if (hist[j-d] != hist[j]) return 1'b0;
      end
      return hist[j-DB-1] != hist[j];
   endfunction

   function automatic logic [3:0] key_of(logic [11:0] v);
      for (int i = 0; i < 12; i++) begin
         if (v[i]) return 4'(i);
      end
      return 4'd0;
   endfunction

   task automatic model_reset();
      mode   = M_IDLE;
      m_code = 4'd0;
      m_held = 0;
      hist   = {};
      repeat (DB + 4) hist.push_back(12'd0);
   endtask

   task automatic model_edge();
      logic [11:0] sv;
      bit          hit;
      int          j;
      hist.push_back(btn);
      j   = hist.size() - 3;   // two synchronizer stages behind the pin
      sv  = hist[j];
      hit = stable_hit(j);
      case (mode)
         M_IDLE: begin
            if (hit && $countones(sv) == 1) begin
               mode   = M_SEND;
               m_code = key_of(sv);
            end
         end
         M_SEND: begin
            if (tx_ready) begin
               mode   = M_RELEASE;
               m_held = 0;
            end
         end
         M_RELEASE: begin
            if (sv == 12'd0 && hit) begin
               mode = M_IDLE;
            end
`ifdef KEY_REPEAT_EN
            else if (m_code < 4'd10 && sv == (12'd1 << m_code)) begin
               m_held++;
               if (m_held == RPT) begin
                  mode   = M_SEND;
                  m_held = 0;
               end
            end else begin
               m_held = 0;
            end
`endif
         end
         default: ;
      endcase
   endtask

   task automatic step();
      if (tx_valid && tx_ready) begin
         dut_xfers++;
         last_code = tx_code;
      end
      @(posedge clk);
      model_edge();
      #1;
      check("tx_valid", tx_valid, (mode == M_SEND));
      check("busy", busy, (mode != M_IDLE));
      check("tx_code", tx_code, m_code);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          x0;
      int          rise;
      int          highs;
      int          rises[$];
      logic        prev_v;
      logic [11:0] v;
      int          dur;

      model_reset();
      #12;
      check("reset_valid", tx_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_code", tx_code, 0);
      #10 rstn = 1'b1;
      tx_ready = 1'b1;
      repeat (10) step();

      // Clean press of digit 5
      x0 = dut_xfers; rise = 0; highs = 0;
      btn = 12'h020;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (tx_valid) begin
            highs++;
            if (rise == 0) rise = i;
         end
      end
      btn = '0;
      repeat (12) step();
      check("press_latency", rise, 7);
      check("press_high_cycles", highs, 1);
      check("press_xfers", dut_xfers - x0, 1);
      check("press_code", last_code, 4'h5);

      // Bounce shorter than the debounce window
      x0 = dut_xfers;
      for (int h = 0; h < 8; h++) begin
         btn = (h % 2 == 0) ? 12'h001 : 12'h000;
         repeat (2) step();
      end
      btn = '0;
      repeat (10) step();
      check("bounce_xfers", dut_xfers - x0, 0);

      // Backpressure on ENTER
      tx_ready = 1'b0;
      btn = 12'h800;
      repeat (7) step();
      check("bp_rise", tx_valid, 1);
      highs = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (tx_valid && tx_code == 4'hB) highs++;
      end
      check("bp_hold_cycles", highs, 10);
      x0 = dut_xfers;
      tx_ready = 1'b1;
      step();
      check("bp_xfer", dut_xfers - x0, 1);
      check("bp_code", last_code, 4'hB);
      check("bp_drop", tx_valid, 0);
      btn = '0;
      repeat (12) step();

      // Multi-key pattern is never a press
      x0 = dut_xfers;
      btn = 12'h003;
      repeat (20) step();
      btn = '0;
      repeat (10) step();
      check("multi_xfers", dut_xfers - x0, 0);

      // Second key pressed while still in RELEASE is discarded
      x0 = dut_xfers;
      btn = 12'h002;
      repeat (10) step();
      btn = 12'h004;
      repeat (20) step();
      btn = '0;
      repeat (12) step();
      check("discard_xfers", dut_xfers - x0, 1);
      check("discard_code", last_code, 4'h1);

      // Asynchronous reset during SEND, key kept held
      tx_ready = 1'b0;
      btn = 12'h010;
      repeat (9) step();
      check("rst_in_send", tx_valid, 1);
      #3 rstn = 1'b0;
      #1;
      check("rst_async_valid", tx_valid, 0);
      check("rst_async_busy", busy, 0);
      check("rst_async_code", tx_code, 0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #3 rstn = 1'b1;
      tx_ready = 1'b1;
      rise = 0;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (tx_valid && rise == 0) rise = i;
      end
      check("rst_redebounce", rise, 7);
      btn = '0;
      repeat (12) step();

      // Long hold of digit 7 (auto-repeats only in the repeat build)
      x0 = dut_xfers;
      rises = {};
      prev_v = tx_valid;
      btn = 12'h080;
      for (int i = 1; i <= 60; i++) begin
         step();
         if (tx_valid && !prev_v) rises.push_back(i);
         prev_v = tx_valid;
      end
      btn = '0;
      repeat (12) step();
      check("hold_xfers", dut_xfers - x0, HOLD_XFERS);
      check("hold_first_rise", (rises.size() > 0) ? rises[0] : -1, 7);
`ifdef KEY_REPEAT_EN
      check("hold_second_rise", (rises.size() > 1) ? rises[1] : -1, 28);
      check("hold_third_rise", (rises.size() > 2) ? rises[2] : -1, 49);
`endif

      // Long hold of CLEAR never repeats
      x0 = dut_xfers;
      btn = 12'h400;
      repeat (60) step();
      btn = '0;
      repeat (12) step();
      check("clear_xfers", dut_xfers - x0, 1);
      check("clear_code", last_code, 4'hA);

      // Random button traffic with random backpressure
      for (int seg = 0; seg < 60; seg++) begin
         case ($urandom_range(0, 3))
            0:       v = 12'd0;
            3:       v = 12'($urandom);
            default: v = 12'd1 << $urandom_range(0, 11);
         endcase
         dur = $urandom_range(1, 14);
         btn = v;
         for (int d = 0; d < dur; d++) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            step();
         end
      end
      btn = '0;
      tx_ready = 1'b1;
      repeat (40) step();
      check("final_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
